tlb_sv39: RTL and testbench
===========================

# tlb_sv39

Fully-associative Sv39 data TLB in front of `ptw_sv39_full`. It translates 39-bit virtual addresses from the load/store unit to 56-bit physical addresses. On a miss it issues a walk request on the PTW request interface, waits for the PTW response, then fills an entry (4 KiB granularity) or reports a page fault. It is the initiator/consumer side of the PTW request/response protocol.

## Interface
Parameters:
- `VADDR_WIDTH`, 39, virtual address width; `ptw_req_vpn` carries a full address with bits [11:0] zero.
- `PPN_WIDTH`, 44, physical page number width.
- `PADDR_WIDTH`, 56, physical address width; equals `PPN_WIDTH`+12.
- `ENTRIES`, 8, TLB entries; power of two, 2..32.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: translation request.
- `req_vaddr` in VADDR_WIDTH: virtual address.
- `req_ready` out 1: high only in IDLE.
- `resp_valid` out 1: one-cycle result pulse.
- `resp_paddr` out PADDR_WIDTH: physical address; 0 on fault.
- `resp_page_fault` out 1: translation fault; qualified by `resp_valid`.
- `satp` in 64: MODE = [63:60] (0 = bare, 8 = Sv39), ASID = [59:44].
- `flush` in 1: sfence.vma (invalidate all entries).
- `ptw_req_valid` out 1, `ptw_req_vpn` out VADDR_WIDTH, `ptw_req_asid` out 16, `ptw_req_ready` in 1: walk request.
- `ptw_resp_valid` in 1, `ptw_resp_ppn` in PPN_WIDTH, `ptw_resp_page_fault` in 1, `ptw_resp_vpn` in VADDR_WIDTH, `ptw_resp_asid` in 16: walk result.

## Operation
- Entry fields: valid, vpn[26:0] (vaddr[38:12]), asid[15:0], ppn[PPN_WIDTH-1:0]. Global bit and superpages are not supported.
- On acceptance (`req_valid && req_ready`), capture `vaddr` and `satp` (mode, ASID) into request registers. `satp` changes after acceptance do not affect the request in flight.
- States: IDLE, LOOKUP, PTW_REQ, PTW_WAIT, RESP.
- **IDLE:** go to LOOKUP on acceptance.
- **LOOKUP, bare mode (MODE=0):** `resp_paddr` = zero-extended vaddr, fault 0; go to RESP.
- **LOOKUP, hit:** a hit is a valid entry with vpn and asid equal to the captured values. `resp_paddr` = {ppn, vaddr[11:0]}; go to RESP. At most one entry can match.
- **LOOKUP, miss:** go to PTW_REQ.
- **PTW_REQ:** `ptw_req_valid`=1, `ptw_req_vpn`={vaddr[38:12],12'b0}, `ptw_req_asid`=captured ASID. Held stable until the first cycle in which `ptw_req_ready`=1 (handshake), then go to PTW_WAIT.
- **PTW_WAIT:** a response is accepted only when `ptw_resp_valid`=1 and `ptw_resp_vpn[38:12]` and `ptw_resp_asid` both match the captured values. Non-matching responses are ignored and the block keeps waiting.
  - Accepted fault: respond with fault=1, paddr=0, no fill.
  - Accepted success: write the entry at the round-robin victim pointer, set it valid, advance the pointer modulo ENTRIES (wraps ENTRIES-1 -> 0), and respond with {ppn, vaddr[11:0]}.
- **RESP:** `resp_valid`=1 for exactly one cycle, then go to IDLE.
- Any MODE other than 0 or 8: fault=1 in LOOKUP with no walk.
- `flush`: clears all valid bits on the sampling edge in any state. The victim pointer is unchanged. An in-flight translation still completes and responds.
  - `flush` coincident with a fill: flush wins, no entry is valid afterwards.
  - `flush` coincident with LOOKUP: the lookup uses pre-flush contents.
- `rst` mid-operation: immediately returns to IDLE, clears all valid bits, victim pointer 0. Any outstanding PTW response arriving afterwards is ignored in IDLE.

## Timing
- Reset values: `req_ready`=1. `resp_valid`, `resp_paddr`, `resp_page_fault`, `ptw_req_valid`, `ptw_req_vpn`, `ptw_req_asid` all 0.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Cycle 0 = acceptance cycle. Hit/bare: LOOKUP cycle 1, `resp_valid` cycle 2, `req_ready` high again cycle 3.
- Miss: `ptw_req_valid` high from cycle 2 through the handshake cycle H. PTW_WAIT starts at H+1. Matching `ptw_resp_valid` in cycle R gives `resp_valid` in R+1 and `req_ready` in R+2.
- `ptw_resp_valid` during PTW_REQ is ignored.
- A filled entry is visible to a lookup in the cycle following the fill edge.

## Test plan
- Reset: hold `rst` 3 cycles, release -> `req_ready`=1, all other outputs 0.
- Cold miss then hit: satp MODE=8, ASID=0x5.
  - vaddr 0x12_3456_7ABC -> `ptw_req_vpn`=0x12_3456_7000, `ptw_req_asid`=0x5.
  - PTW returns ppn 0xABCDE -> `resp_paddr`=0xABCDE_ABC, fault 0.
  - Repeat same vaddr -> response in cycle 2, no PTW request.
- PTW fault: response with page_fault=1 -> `resp_page_fault`=1, `resp_paddr`=0; a retry of the same vaddr walks again.
- ASID/stale filtering:
  - Fill under ASID 5, look up under ASID 6 -> miss and walk.
  - A PTW response with wrong vpn is ignored until a matching one arrives.
- Eviction wrap: with ENTRIES=8, fill 9 distinct VPNs -> the first VPN misses, the ninth hits, and the victim pointer equals 1.
- Flush and bare:
  - `flush` during PTW_WAIT -> response still delivered, but the next access to that VPN misses.
  - MODE=0, vaddr 0x7F_FFFF_FFFF -> paddr 0x00_007F_FFFF_FFFF in cycle 2, no walk.

Source files
------------

// File: rtl/tlb_sv39_if.sv
// Bundle of the translation request/response port and the page-table-walker
// request/response port of the Sv39 data TLB. The slave modport is the TLB
// itself; the master modport is its environment (load/store unit plus PTW).
interface tlb_sv39_if #(
  parameter int VADDR_WIDTH = 39,
  parameter int PPN_WIDTH   = 44,
  parameter int PADDR_WIDTH = 56
);
  // Translation request / response
  logic                   req_valid;
  logic [VADDR_WIDTH-1:0] req_vaddr;
  logic                   req_ready;
  logic                   resp_valid;
  logic [PADDR_WIDTH-1:0] resp_paddr;
  logic                   resp_page_fault;

  // Address-translation context
  logic [63:0]            satp;
  logic                   flush;

  // Walk request
  logic                   ptw_req_valid;
  logic [VADDR_WIDTH-1:0] ptw_req_vpn;
  logic [15:0]            ptw_req_asid;
  logic                   ptw_req_ready;

  // Walk response
  logic                   ptw_resp_valid;
  logic [PPN_WIDTH-1:0]   ptw_resp_ppn;
  logic                   ptw_resp_page_fault;
  logic [VADDR_WIDTH-1:0] ptw_resp_vpn;
  logic [15:0]            ptw_resp_asid;

  modport master (
    output req_valid, req_vaddr, satp, flush, ptw_req_ready,
           ptw_resp_valid, ptw_resp_ppn, ptw_resp_page_fault, ptw_resp_vpn, ptw_resp_asid,
    input  req_ready, resp_valid, resp_paddr, resp_page_fault,
           ptw_req_valid, ptw_req_vpn, ptw_req_asid
  );

  modport slave (
    input  req_valid, req_vaddr, satp, flush, ptw_req_ready,
           ptw_resp_valid, ptw_resp_ppn, ptw_resp_page_fault, ptw_resp_vpn, ptw_resp_asid,
    output req_ready, resp_valid, resp_paddr, resp_page_fault,
           ptw_req_valid, ptw_req_vpn, ptw_req_asid
  );
endinterface

// File: rtl/tlb_sv39.sv
// Fully-associative Sv39 data TLB (4 KiB pages only, no global bit).
// A miss issues one walk to the PTW, then fills the round-robin victim entry
// or reports a page fault. All outputs come from registers or the state.
module tlb_sv39 #(
  parameter int VADDR_WIDTH = 39,
  parameter int PPN_WIDTH   = 44,
  parameter int PADDR_WIDTH = 56,
  parameter int ENTRIES     = 8
) (
  input  logic      clk,
  input  logic      rst,
  tlb_sv39_if.slave bus
);

  localparam int VPN_W = VADDR_WIDTH - 12;
  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [3:0] MODE_BARE = 4'd0;
  localparam logic [3:0] MODE_SV39 = 4'd8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_PTW_REQ  = 3'd2;
  localparam logic [2:0] S_PTW_WAIT = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]             state_q;
  logic [VADDR_WIDTH-1:0] req_vaddr_q;
  logic [3:0]             req_mode_q;
  logic [15:0]            req_asid_q;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic                   fault_q;
  logic [IDX_W-1:0]       victim_q;

  logic [ENTRIES-1:0]     valid_q;
  logic [VPN_W-1:0]       ent_vpn  [ENTRIES];
  logic [15:0]            ent_asid [ENTRIES];
  logic [PPN_WIDTH-1:0]   ent_ppn  [ENTRIES];

  logic [VPN_W-1:0]       req_vpn;
  logic                   hit;
  logic [PPN_WIDTH-1:0]   hit_ppn;
  logic                   resp_match;
  logic                   fill_en;

  assign req_vpn = req_vaddr_q[VADDR_WIDTH-1:12];

  // Associative match of the captured VPN/ASID against every valid entry
  always_comb begin
    // NOTE: every signal gets a default before the loop so no latch is inferred.
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && ent_vpn[i] == req_vpn && ent_asid[i] == req_asid_q) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | ent_ppn[i];
      end
    end
  end

  // Only a response for the walk we issued is accepted; stale ones are dropped
  assign resp_match = bus.ptw_resp_valid
                   && bus.ptw_resp_vpn[VADDR_WIDTH-1:12] == req_vpn
                   && bus.ptw_resp_asid == req_asid_q;
  assign fill_en    = (state_q == S_PTW_WAIT) && resp_match && !bus.ptw_resp_page_fault;

  // Translation FSM, request capture, response registers and victim pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together on the edge regardless of statement order.
      state_q     <= S_IDLE;
      req_vaddr_q <= '0;
      req_mode_q  <= '0;
      req_asid_q  <= '0;
      paddr_q     <= '0;
      fault_q     <= 1'b0;
      victim_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            req_vaddr_q <= bus.req_vaddr;
            req_mode_q  <= bus.satp[63:60];
            req_asid_q  <= bus.satp[59:44];
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (req_mode_q == MODE_BARE) begin
            paddr_q <= {{(PADDR_WIDTH-VADDR_WIDTH){1'b0}}, req_vaddr_q};
            fault_q <= 1'b0;
            state_q <= S_RESP;
          end else if (req_mode_q != MODE_SV39) begin
            paddr_q <= '0;
            fault_q <= 1'b1;
            state_q <= S_RESP;
          end else if (hit) begin
            paddr_q <= {hit_ppn, req_vaddr_q[11:0]};
            fault_q <= 1'b0;
            state_q <= S_RESP;
          end else begin
            state_q <= S_PTW_REQ;
          end
        end
        S_PTW_REQ: begin
          if (bus.ptw_req_ready) state_q <= S_PTW_WAIT;
        end
        S_PTW_WAIT: begin
          if (resp_match) begin
            fault_q <= bus.ptw_resp_page_fault;
            if (bus.ptw_resp_page_fault) begin
              paddr_q <= '0;
            end else begin
              paddr_q  <= {bus.ptw_resp_ppn, req_vaddr_q[11:0]};
              victim_q <= (victim_q == IDX_W'(ENTRIES-1)) ? '0 : victim_q + 1'b1;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Valid bits: flush beats a coincident fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           valid_q <= '0;
    else if (bus.flush) valid_q <= '0;
    else if (fill_en)  valid_q[victim_q] <= 1'b1;
  end

  // Entry payload is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    // NOTE: the payload arrays are deliberately not reset; valid_q guards them.
    if (fill_en) begin
      ent_vpn[victim_q]  <= req_vpn;
      ent_asid[victim_q] <= req_asid_q;
      ent_ppn[victim_q]  <= bus.ptw_resp_ppn;
    end
  end

  assign bus.req_ready       = (state_q == S_IDLE);
  assign bus.resp_valid      = (state_q == S_RESP);
  assign bus.resp_paddr      = paddr_q;
  assign bus.resp_page_fault = fault_q;
  assign bus.ptw_req_valid   = (state_q == S_PTW_REQ);
  assign bus.ptw_req_vpn     = (state_q == S_PTW_REQ) ? {req_vpn, 12'h000} : '0;
  assign bus.ptw_req_asid    = (state_q == S_PTW_REQ) ? req_asid_q : '0;

  // satp PPN field and the walk response page offset are not needed here
  logic unused_ok;
  assign unused_ok = ^{bus.satp[43:0], bus.ptw_resp_vpn[11:0]};

endmodule

// File: tb/tb_tlb_sv39.sv
// Directed bench for tlb_sv39: the bench plays load/store unit and PTW.
module tb_tlb_sv39;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  tlb_sv39_if #(.VADDR_WIDTH(39), .PPN_WIDTH(44), .PADDR_WIDTH(56)) bus ();

  tlb_sv39 #(.VADDR_WIDTH(39), .PPN_WIDTH(44), .PADDR_WIDTH(56), .ENTRIES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the last translate() call
  logic [55:0] t_pa;
  logic        t_flt;
  int          t_lat;
  bit          t_walked;
  bit          t_unstable;
  logic [38:0] t_vpn;
  logic [15:0] t_asid;
  logic        t_rdy0;
  logic        t_rdy1;

  function automatic logic [63:0] satp_of(input logic [3:0] mode, input logic [15:0] asid);
    return {mode, asid, 44'h0};
  endfunction

  // One translation, with the bench answering any walk request.
  // delay: cycles ptw_req_ready is held low; bogus: wrong-VPN responses first;
  // flush_at_resp: flush raised in the same cycle as the real response.
  task automatic translate(input logic [38:0] va, input logic [43:0] ppn, input logic pf,
                           input int delay, input int bogus, input bit flush_at_resp);
    logic [15:0] a0;
    int cyc, held, nb;
    bit sent;
    a0 = bus.satp[59:44];
    t_lat = -1; t_walked = 0; t_unstable = 0; t_vpn = '0; t_asid = '0;
    t_pa = '0; t_flt = 1'b0; t_rdy1 = 1'b0;
    cyc = 0; held = 0; nb = 0; sent = 0;
    @(negedge clk);
    t_rdy0 = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_vaddr = va;
    while (t_lat < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.req_valid = 1'b0; bus.ptw_req_ready = 1'b0; bus.ptw_resp_valid = 1'b0; bus.flush = 1'b0;
      if (cyc == 1) t_rdy1 = bus.req_ready;
      if (bus.resp_valid) begin
        t_pa  = bus.resp_paddr;
        t_flt = bus.resp_page_fault;
        t_lat = cyc;
      end else if (bus.ptw_req_valid) begin
        if (!t_walked) begin
          t_vpn  = bus.ptw_req_vpn;
          t_asid = bus.ptw_req_asid;
        end else if (bus.ptw_req_vpn !== t_vpn || bus.ptw_req_asid !== t_asid) begin
          t_unstable = 1;
        end
        t_walked = 1;
        if (held >= delay) bus.ptw_req_ready = 1'b1;
        else held++;
      end else if (t_walked && !sent) begin
        bus.ptw_resp_valid      = 1'b1;
        bus.ptw_resp_asid       = a0;
        bus.ptw_resp_ppn        = ppn;
        bus.ptw_resp_page_fault = pf;
        if (nb < bogus) begin
          bus.ptw_resp_vpn = {~va[38:12], 12'h000};
          nb++;
        end else begin
          bus.ptw_resp_vpn = {va[38:12], 12'h000};
          bus.flush        = flush_at_resp;
          sent             = 1;
        end
      end
    end
    if (t_lat < 0) begin
      checks++; failures++;
      $display("FAIL translate_timeout va=%0h got no resp_valid within 100 cycles", va);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_paddr !== 56'h0 || bus.resp_page_fault !== 1'b0) begin failures++; $display("FAIL reset_resp got paddr=%0h fault=%b exp 0/0", bus.resp_paddr, bus.resp_page_fault); end
    checks++; if (bus.ptw_req_valid !== 1'b0 || bus.ptw_req_vpn !== 39'h0 || bus.ptw_req_asid !== 16'h0) begin failures++; $display("FAIL reset_ptw_req got v=%b vpn=%0h asid=%0h exp 0", bus.ptw_req_valid, bus.ptw_req_vpn, bus.ptw_req_asid); end
  endtask

  task automatic test_miss_hit();
    bus.satp = satp_of(4'h8, 16'h5);
    translate(39'h12_3456_7ABC, 44'hABCDE, 1'b0, 2, 0, 1'b0);
    checks++; if (t_rdy0 !== 1'b1 || t_rdy1 !== 1'b0) begin failures++; $display("FAIL miss_req_ready got c0=%b c1=%b exp 1/0", t_rdy0, t_rdy1); end
    checks++; if (t_vpn !== 39'h12_3456_7000) begin failures++; $display("FAIL miss_ptw_vpn got=%0h exp=1234567000", t_vpn); end
    checks++; if (t_asid !== 16'h5) begin failures++; $display("FAIL miss_ptw_asid got=%0h exp=5", t_asid); end
    checks++; if (t_unstable) begin failures++; $display("FAIL miss_ptw_stable got=unstable exp=stable"); end
    checks++; if (t_pa !== 56'hABCDE_ABC || t_flt !== 1'b0) begin failures++; $display("FAIL miss_paddr got=%0h fault=%b exp=abcdeabc/0", t_pa, t_flt); end
    checks++; if (t_lat != 6) begin failures++; $display("FAIL miss_latency got=%0d exp=6", t_lat); end
    translate(39'h12_3456_7ABC, 44'h0, 1'b0, 0, 0, 1'b0);
    checks++; if (t_walked || t_lat != 2) begin failures++; $display("FAIL hit_nowalk got walked=%0d lat=%0d exp 0/2", t_walked, t_lat); end
    checks++; if (t_pa !== 56'hABCDE_ABC) begin failures++; $display("FAIL hit_paddr got=%0h exp=abcdeabc", t_pa); end
  endtask

  task automatic test_fault();
    translate(39'h00_1111_2345, 44'h123, 1'b1, 0, 0, 1'b0);
    checks++; if (t_flt !== 1'b1 || t_pa !== 56'h0) begin failures++; $display("FAIL fault_resp got fault=%b paddr=%0h exp 1/0", t_flt, t_pa); end
    checks++; if (t_lat != 4) begin failures++; $display("FAIL fault_latency got=%0d exp=4", t_lat); end
    translate(39'h00_1111_2345, 44'h777, 1'b0, 0, 0, 1'b0);
    checks++; if (!t_walked) begin failures++; $display("FAIL fault_retry_walk got walked=0 exp=1"); end
    checks++; if (t_pa !== 56'h777_345 || t_flt !== 1'b0) begin failures++; $display("FAIL fault_retry_paddr got=%0h fault=%b exp=777345/0", t_pa, t_flt); end
  endtask

  task automatic test_asid();
    bus.satp = satp_of(4'h8, 16'h6);
    translate(39'h12_3456_7ABC, 44'h55555, 1'b0, 0, 0, 1'b0);
    checks++; if (!t_walked || t_asid !== 16'h6) begin failures++; $display("FAIL asid_miss got walked=%0d asid=%0h exp 1/6", t_walked, t_asid); end
    checks++; if (t_pa !== 56'h5555_5ABC) begin failures++; $display("FAIL asid_paddr got=%0h exp=55555abc", t_pa); end
    bus.satp = satp_of(4'h8, 16'h5);
    translate(39'h12_3456_7ABC, 44'h0, 1'b0, 0, 0, 1'b0);
    checks++; if (t_walked || t_pa !== 56'hABCDE_ABC) begin failures++; $display("FAIL asid_old_hit got walked=%0d paddr=%0h exp 0/abcdeabc", t_walked, t_pa); end
    bus.satp = satp_of(4'h8, 16'h6);
    translate(39'h03_0000_0010, 44'h42, 1'b0, 0, 3, 1'b0);
    checks++; if (t_lat != 7) begin failures++; $display("FAIL stale_resp_latency got=%0d exp=7", t_lat); end
    checks++; if (t_pa !== 56'h42_010) begin failures++; $display("FAIL stale_resp_paddr got=%0h exp=42010", t_pa); end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.satp = satp_of(4'h8, 16'h5);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_vaddr = 39'h05_5555_5111;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.ptw_req_valid && n < 10) begin @(negedge clk); n++; end
    checks++; if (!bus.ptw_req_valid) begin failures++; $display("FAIL rstmid_walk got ptw_req_valid=0 exp=1"); end
    bus.ptw_req_ready = 1'b1;
    @(negedge clk);
    bus.ptw_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_idle got req_ready=%b exp=1", bus.req_ready); end
    bus.ptw_resp_valid = 1'b1; bus.ptw_resp_vpn = 39'h05_5555_5000; bus.ptw_resp_asid = 16'h5;
    bus.ptw_resp_ppn = 44'h3; bus.ptw_resp_page_fault = 1'b0;
    @(negedge clk);
    bus.ptw_resp_valid = 1'b0;
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.ptw_req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale got resp_valid=%b req_ready=%b ptw_req_valid=%b exp 0/1/0", bus.resp_valid, bus.req_ready, bus.ptw_req_valid); end
  endtask

  task automatic test_eviction();
    logic [26:0] vpn;
    bus.satp = satp_of(4'h8, 16'h5);
    for (int i = 0; i < 9; i++) begin
      vpn = 27'h123_4567 + 27'(i);
      translate({vpn, 12'hABC}, 44'h1000 + 44'(i), 1'b0, 0, 0, 1'b0);
      checks++; if (!t_walked) begin failures++; $display("FAIL evict_fill%0d got walked=0 exp=1", i); end
    end
    checks++; if (dut.victim_q !== 3'd1) begin failures++; $display("FAIL evict_victim got=%0d exp=1", dut.victim_q); end
    vpn = 27'h123_4567 + 27'd8;
    translate({vpn, 12'hABC}, 44'h0, 1'b0, 0, 0, 1'b0);
    checks++; if (t_walked || t_pa !== 56'h1008_ABC) begin failures++; $display("FAIL evict_ninth_hit got walked=%0d paddr=%0h exp 0/1008abc", t_walked, t_pa); end
    translate(39'h12_3456_7ABC, 44'h1000, 1'b0, 0, 0, 1'b0);
    checks++; if (!t_walked) begin failures++; $display("FAIL evict_first_miss got walked=0 exp=1"); end
  endtask

  task automatic test_flush();
    bus.satp = satp_of(4'h8, 16'h5);
    translate(39'h07_0000_0123, 44'h99, 1'b0, 0, 0, 1'b1);
    checks++; if (t_pa !== 56'h99_123 || t_flt !== 1'b0) begin failures++; $display("FAIL flush_resp got=%0h fault=%b exp=99123/0", t_pa, t_flt); end
    translate(39'h07_0000_0123, 44'h99, 1'b0, 0, 0, 1'b0);
    checks++; if (!t_walked) begin failures++; $display("FAIL flush_refill got walked=0 exp=1"); end
    translate(39'h12_3456_8ABC, 44'h1008, 1'b0, 0, 0, 1'b0);
    checks++; if (!t_walked) begin failures++; $display("FAIL flush_clears_all got walked=0 exp=1"); end
  endtask

  task automatic test_bare();
    bus.satp = satp_of(4'h0, 16'h5);
    translate(39'h7F_FFFF_FFFF, 44'h0, 1'b0, 0, 0, 1'b0);
    checks++; if (t_pa !== 56'h00_007F_FFFF_FFFF || t_flt !== 1'b0) begin failures++; $display("FAIL bare_paddr got=%0h fault=%b exp=7fffffffff/0", t_pa, t_flt); end
    checks++; if (t_walked || t_lat != 2) begin failures++; $display("FAIL bare_timing got walked=%0d lat=%0d exp 0/2", t_walked, t_lat); end
    bus.satp = satp_of(4'h9, 16'h5);
    translate(39'h12_3456_7ABC, 44'h0, 1'b0, 0, 0, 1'b0);
    checks++; if (t_flt !== 1'b1 || t_pa !== 56'h0 || t_walked || t_lat != 2) begin failures++; $display("FAIL badmode got fault=%b paddr=%0h walked=%0d lat=%0d exp 1/0/0/2", t_flt, t_pa, t_walked, t_lat); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_vaddr = '0; bus.satp = '0; bus.flush = 1'b0;
    bus.ptw_req_ready = 1'b0; bus.ptw_resp_valid = 1'b0; bus.ptw_resp_ppn = '0;
    bus.ptw_resp_page_fault = 1'b0; bus.ptw_resp_vpn = '0; bus.ptw_resp_asid = '0;
    test_reset();
    test_miss_hit();
    test_fault();
    test_asid();
    test_reset_mid();
    test_eviction();
    test_flush();
    test_bare();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
